// File: rtl/controller2_gamepad_if.sv
// Pad-side signal bundle for the NES-style gamepad controller.
// master = controller (drives GPulse/GLatch/GamePad), slave = pad/consumer side.
interface controller2_gamepad_if;
    logic       GamePadData;
    logic [7:0] GamePad;
    logic       GPulse;
    logic       GLatch;

    modport master (
        input  GamePadData,
        output GamePad,
        output GPulse,
        output GLatch
    );

    modport slave (
        output GamePadData,
        input  GamePad,
        input  GPulse,
        input  GLatch
    );
endinterface

// File: rtl/controller2_gamepad.sv
// NES-style gamepad poller: latch, shift eight active-low bits MSB first (A first),
// publish the inverted byte atomically once per POLL_CYCLES frame.
module controller2_gamepad #(
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_PERIOD  = 150,
    parameter int POLL_CYCLES  = 416667
) (
    input  logic                  Clock,
    input  logic                  Reset,
    controller2_gamepad_if.master pad,
    output logic [2:0]            dbg_state
);

    // No handshake: the pad is a free-running slave clocked by GLatch/GPulse,
    // and GamePad is a level that only changes in the cycle after DONE.

    localparam int MAX_PHASE = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);
    localparam int FRAME_W   = $clog2(POLL_CYCLES + 1);

    localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [FRAME_W-1:0] POLL_LAST  = FRAME_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LATCH      = 3'd1,
        READ_LOW   = 3'd2,
        PULSE_HIGH = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic [7:0]         shift, shift_n;
    logic [FRAME_W-1:0] frame_cnt;
    logic               sync1, sync2;
    logic               load;

    assign dbg_state = state;

    // Frame counter runs regardless of state so frame starts stay on a fixed grid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_cnt <= '0;
        end else if (frame_cnt == POLL_LAST) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad.GamePadData;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (frame_cnt == '0) state_n = LATCH;
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    cnt_n   = '0;
                    state_n = READ_LOW;
                end
            end
            READ_LOW: begin
                // Sample at the end of the low phase; data was set up on the prior GPulse edge.
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {shift[6:0], ~sync2};
                    bit_cnt_n = bit_cnt + 1'b1;
                    state_n   = (bit_cnt == 3'd7) ? DONE : PULSE_HIGH;
                end
            end
            PULSE_HIGH: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = READ_LOW;
                end
            end
            DONE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                load      = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            pad.GamePad <= '0;
            pad.GLatch  <= 1'b0;
            pad.GPulse  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            pad.GLatch <= (state_n == LATCH);
            pad.GPulse <= (state_n == PULSE_HIGH);
            if (load) pad.GamePad <= shift;
        end
    end

endmodule

// File: tb/tb_controller2_gamepad.sv
// Directed bench for controller2_gamepad with a shift-register pad model and
// small timing parameters (latch 4, half period 2, frame 64).
module tb_controller2_gamepad;

  localparam int LATCH_CYCLES = 4;
  localparam int HALF_PERIOD  = 2;
  localparam int POLL_CYCLES  = 64;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  controller2_gamepad_if bus ();

  controller2_gamepad #(
    .LATCH_CYCLES (LATCH_CYCLES),
    .HALF_PERIOD  (HALF_PERIOD),
    .POLL_CYCLES  (POLL_CYCLES)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .pad       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 Clock = ~Clock;

  // Pad model: parallel-load on GLatch rise, shift toward bit 7 on GPulse rise (4021-like).
  logic [7:0] pad_raw = 8'hFF;
  logic [7:0] pad_sr;
  logic       glitch_en  = 1'b0;
  logic       glitch_val = 1'b1;

  always @(posedge bus.GLatch or posedge bus.GPulse) begin
    if (bus.GLatch) pad_sr = pad_raw;
    else            pad_sr = {pad_sr[6:0], 1'b1};
  end

  assign bus.GamePadData = glitch_en ? glitch_val : pad_sr[7];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobe exclusivity and quiet IDLE, checked every cycle outside reset.
  always @(negedge Clock) begin
    if (!Reset) begin
      check("no_overlap", {7'b0, bus.GLatch & bus.GPulse}, 8'h00);
      if (dbg_state == 3'd0) check("idle_gpulse", {7'b0, bus.GPulse}, 8'h00);
    end
  end

  // Entered at the negedge of frame cycle 0; leaves at cycle 0 of the following frame.
  task automatic run_frame(input logic [7:0] gp_before, input logic [7:0] gp_after,
                           input logic [7:0] next_raw, input bit glitch);
    int   pulses  = 0;
    int   latches = 0;
    logic prev_p  = 1'b0;
    logic prev_l  = 1'b0;
    logic exp_l, exp_p;
    for (int t = 0; t < POLL_CYCLES; t++) begin
      exp_l = (t < 4);
      exp_p = (t >= 6) && (t <= 33) && (((t - 4) % 4) >= 2);
      check("glatch",  {7'b0, bus.GLatch}, {7'b0, exp_l});
      check("gpulse",  {7'b0, bus.GPulse}, {7'b0, exp_p});
      check("gamepad", bus.GamePad, (t < 35) ? gp_before : gp_after);
      if (bus.GPulse && !prev_p) pulses++;
      if (bus.GLatch && !prev_l) latches++;
      prev_p = bus.GPulse;
      prev_l = bus.GLatch;
      if (t == 10) pad_raw = next_raw;
      if (glitch && t >= 40 && t <= 60) begin
        glitch_en  = 1'b1;
        glitch_val = 1'($urandom_range(0, 1));
      end
      if (t == 61) glitch_en = 1'b0;
      @(negedge Clock);
    end
    check("latch_count", 8'(latches), 8'd1);
    check("pulse_count", 8'(pulses),  8'd7);
  endtask

  initial begin
    pad_raw = 8'h7E;
    repeat (3) @(negedge Clock);
    check("rst_gamepad", bus.GamePad, 8'h00);
    check("rst_glatch",  {7'b0, bus.GLatch}, 8'h00);
    check("rst_gpulse",  {7'b0, bus.GPulse}, 8'h00);
    check("rst_state",   {5'b0, dbg_state},  8'h00);

    Reset = 1'b0;
    @(negedge Clock);
    run_frame(8'h00, 8'h81, 8'hFF, 1'b0);
    run_frame(8'h81, 8'h00, 8'h00, 1'b1);
    run_frame(8'h00, 8'hFF, 8'h7E, 1'b0);
    run_frame(8'hFF, 8'h81, 8'hDB, 1'b0);
    run_frame(8'h81, 8'h24, 8'hDB, 1'b1);

    // Abort a frame in the middle of a GPulse high phase.
    repeat (18) @(negedge Clock);
    check("mid_gpulse", {7'b0, bus.GPulse}, 8'h01);
    check("mid_state",  {5'b0, dbg_state},  8'h03);
    Reset   = 1'b1;
    pad_raw = 8'hC3;
    @(negedge Clock);
    check("abort_gamepad", bus.GamePad, 8'h00);
    check("abort_glatch",  {7'b0, bus.GLatch}, 8'h00);
    check("abort_gpulse",  {7'b0, bus.GPulse}, 8'h00);
    check("abort_state",   {5'b0, dbg_state},  8'h00);
    Reset = 1'b0;
    @(negedge Clock);
    run_frame(8'h00, 8'h3C, 8'hC3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
